// File: rtl/quad_sum_count_seq.sv
// Sequential quadruple-sum counter: walks every i<j<m<l over N W-bit elements, one per clock,
// counting sums equal to k. Define QUAD_CNT_SAT_EN for a saturating count with sticky ovf.
module quad_sum_count_seq #(
   parameter int N  = 100,
   parameter int W  = 1,
   parameter int CW = 22
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            clear,
   input  logic [N*W-1:0]  input_array,
   input  logic [W+1:0]    k,
   output logic            busy,
   output logic            done,
   output logic [CW-1:0]   count
`ifdef QUAD_CNT_SAT_EN
   ,
   output logic            ovf
`endif
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;
   typedef logic [IW-1:0] idx_t;

   localparam idx_t LAST_I = idx_t'(N - 4);
   localparam idx_t NM1    = idx_t'(N - 1);
   localparam idx_t NM2    = idx_t'(N - 2);
   localparam idx_t NM3    = idx_t'(N - 3);

   generate
      if (N < 4) begin : g_n_check
         $error("quad_sum_count_seq: N must be at least 4");
      end
   endgenerate

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   idx_t            i_q, i_d, j_q, j_d, m_q, m_d, l_q, l_d;
   logic [CW-1:0]   count_q, count_d;
   logic [N*W-1:0]  arr_q, arr_d;
   logic [W+1:0]    k_q, k_d;
   logic [W+1:0]    sum;
   logic            match;
`ifdef QUAD_CNT_SAT_EN
   logic            ovf_q, ovf_d;
`endif

   function automatic logic [W-1:0] elem(input logic [N*W-1:0] a, input idx_t e);
      return a[int'(e)*W +: W];
   endfunction

   function automatic logic [CW-1:0] cnt_inc(input logic [CW-1:0] c);
`ifdef QUAD_CNT_SAT_EN
      return (&c) ? c : c + CW'(1);
`else
      return c + CW'(1);
`endif
   endfunction

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      m_d     = m_q;
      l_d     = l_q;
      count_d = count_q;
      arr_d   = arr_q;
      k_d     = k_q;
`ifdef QUAD_CNT_SAT_EN
      ovf_d   = ovf_q;
`endif
      // Two guard bits keep the four-way sum exact: 4*(2^W-1) < 2^(W+2).
      sum   = {2'b00, elem(arr_q, i_q)} + {2'b00, elem(arr_q, j_q)}
            + {2'b00, elem(arr_q, m_q)} + {2'b00, elem(arr_q, l_q)};
      match = (sum == k_q);

      if (clear) begin
         state_d = S_IDLE;
         count_d = '0;
`ifdef QUAD_CNT_SAT_EN
         ovf_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_d = S_RUN;
                  arr_d   = input_array;
                  k_d     = k;
                  count_d = '0;
                  i_d     = idx_t'(0);
                  j_d     = idx_t'(1);
                  m_d     = idx_t'(2);
                  l_d     = idx_t'(3);
`ifdef QUAD_CNT_SAT_EN
                  ovf_d   = 1'b0;
`endif
               end
            end
            S_RUN: begin
               if (match) begin
                  count_d = cnt_inc(count_q);
`ifdef QUAD_CNT_SAT_EN
                  ovf_d   = ovf_q | (&count_q);
`endif
               end
               // i reaching N-4 forces (j,m,l) = (N-3,N-2,N-1): the final quadruple.
               if (i_q == LAST_I) begin
                  state_d = S_DONE;
               end else if (l_q < NM1) begin
                  l_d = l_q + idx_t'(1);
               end else if (m_q < NM2) begin
                  m_d = m_q + idx_t'(1);
                  l_d = m_q + idx_t'(2);
               end else if (j_q < NM3) begin
                  j_d = j_q + idx_t'(1);
                  m_d = j_q + idx_t'(2);
                  l_d = j_q + idx_t'(3);
               end else begin
                  i_d = i_q + idx_t'(1);
                  j_d = i_q + idx_t'(2);
                  m_d = i_q + idx_t'(3);
                  l_d = i_q + idx_t'(4);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         i_q     <= '0;
         j_q     <= '0;
         m_q     <= '0;
         l_q     <= '0;
         count_q <= '0;
`ifdef QUAD_CNT_SAT_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         m_q     <= m_d;
         l_q     <= l_d;
         count_q <= count_d;
`ifdef QUAD_CNT_SAT_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   // Captured operands only matter while RUN, so they carry no reset.
   always_ff @(posedge clk) begin
      arr_q <= arr_d;
      k_q   <= k_d;
   end

   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign count = count_q;
`ifdef QUAD_CNT_SAT_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_quad_sum_count_seq.sv
// Scoreboard bench for quad_sum_count_seq: two N=8 instances (CW=8 and CW=4) share stimulus,
// a third N=12,W=3 instance runs random arrays; expected counts come from a nested-loop model.
module tb_quad_sum_count_seq;

   localparam int NA = 8, WA = 2, CWA = 8, CWB = 4;
   localparam int NC = 12, WC = 3, CWC = 10;
   localparam int LAT_A = 70, LAT_C = 495;

   typedef int iq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_n, start_a, clear_a, start_c, clear_c;
   logic [NA*WA-1:0]    arr_a;
   logic [WA+1:0]       k_a;
   logic [NC*WC-1:0]    arr_c;
   logic [WC+1:0]       k_c;
   logic                busy_a, done_a, busy_b, done_b, busy_c, done_c;
   logic [CWA-1:0]      count_a;
   logic [CWB-1:0]      count_b;
   logic [CWC-1:0]      count_c;
`ifdef QUAD_CNT_SAT_EN
   logic                ovf_a, ovf_b, ovf_c;
`endif

   quad_sum_count_seq #(.N(NA), .W(WA), .CW(CWA)) u_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a),
      .input_array(arr_a), .k(k_a), .busy(busy_a), .done(done_a), .count(count_a)
`ifdef QUAD_CNT_SAT_EN
      , .ovf(ovf_a)
`endif
   );

   quad_sum_count_seq #(.N(NA), .W(WA), .CW(CWB)) u_b (
      .clk(clk), .rst_n(rst_n), .start(start_a), .clear(clear_a),
      .input_array(arr_a), .k(k_a), .busy(busy_b), .done(done_b), .count(count_b)
`ifdef QUAD_CNT_SAT_EN
      , .ovf(ovf_b)
`endif
   );

   quad_sum_count_seq #(.N(NC), .W(WC), .CW(CWC)) u_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .clear(clear_c),
      .input_array(arr_c), .k(k_c), .busy(busy_c), .done(done_c), .count(count_c)
`ifdef QUAD_CNT_SAT_EN
      , .ovf(ovf_c)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int exp_a_q[$];
   int exp_c_q[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: plain enumeration of all index quadruples.
   function automatic int quad_ref(input iq_t e, input int kk);
      int n = 0;
      for (int i = 0; i < e.size(); i++)
         for (int j = i + 1; j < e.size(); j++)
            for (int m = j + 1; m < e.size(); m++)
               for (int l = m + 1; l < e.size(); l++)
                  if (e[i] + e[j] + e[m] + e[l] == kk) n++;
      return n;
   endfunction

   function automatic int narrow_exp(input int e);
`ifdef QUAD_CNT_SAT_EN
      return (e > 15) ? 15 : e;
`else
      return e % 16;
`endif
   endfunction

   function automatic iq_t fill(input int n, input int v);
      iq_t q;
      for (int i = 0; i < n; i++) q.push_back(v);
      return q;
   endfunction

   function automatic iq_t rand_q(input int n, input int maxv);
      iq_t q;
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, maxv)));
      return q;
   endfunction

   function automatic logic [NA*WA-1:0] pack_a(input iq_t e);
      logic [NA*WA-1:0] p = '0;
      for (int i = 0; i < NA; i++) p[i*WA +: WA] = WA'(e[i]);
      return p;
   endfunction

   function automatic logic [NC*WC-1:0] pack_c(input iq_t e);
      logic [NC*WC-1:0] p = '0;
      for (int i = 0; i < NC; i++) p[i*WC +: WC] = WC'(e[i]);
      return p;
   endfunction

   // Monitor for the shared-stimulus pair: compares on each rising done.
   initial begin
      int bcnt = 0;
      logic prev = 1'b0;
      int e;
      forever begin
         @(negedge clk);
         if (done_a && !prev) begin
            if (exp_a_q.size() == 0) begin
               chk("sb_a_unexpected_done", exp_a_q.size(), 1);
            end else begin
               e = exp_a_q.pop_front();
               chk("count_a", count_a, e);
               chk("count_b", count_b, narrow_exp(e));
               chk("done_b", done_b, 1);
               chk("latency_a", bcnt, LAT_A);
`ifdef QUAD_CNT_SAT_EN
               chk("ovf_a", ovf_a, 0);
               chk("ovf_b", ovf_b, (e > 15) ? 1 : 0);
`endif
            end
            bcnt = 0;
         end else if (busy_a) begin
            bcnt++;
         end else if (!done_a) begin
            bcnt = 0;
         end
         prev = done_a;
      end
   end

   initial begin
      int bcnt = 0;
      logic prev = 1'b0;
      int e;
      forever begin
         @(negedge clk);
         if (done_c && !prev) begin
            if (exp_c_q.size() == 0) begin
               chk("sb_c_unexpected_done", exp_c_q.size(), 1);
            end else begin
               e = exp_c_q.pop_front();
               chk("count_c", count_c, e);
               chk("latency_c", bcnt, LAT_C);
`ifdef QUAD_CNT_SAT_EN
               chk("ovf_c", ovf_c, 0);
`endif
            end
            bcnt = 0;
         end else if (busy_c) begin
            bcnt++;
         end else if (!done_c) begin
            bcnt = 0;
         end
         prev = done_c;
      end
   end

   task automatic wait_a();
      int c = 0;
      while (!done_a && c < LAT_A + 20) begin
         @(negedge clk);
         c++;
      end
      if (!done_a) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout_a: done not seen after %0d cycles, required within %0d", c, LAT_A);
         exp_a_q.delete();
      end
   endtask

   task automatic wait_c();
      int c = 0;
      while (!done_c && c < LAT_C + 20) begin
         @(negedge clk);
         c++;
      end
      if (!done_c) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout_c: done not seen after %0d cycles, required within %0d", c, LAT_C);
         exp_c_q.delete();
      end
   endtask

   task automatic run_a(input iq_t e, input int kk, input int exp);
      arr_a   = pack_a(e);
      k_a     = (WA + 2)'(kk);
      start_a = 1'b1;
      exp_a_q.push_back(exp);
      @(negedge clk);
      start_a = 1'b0;
      wait_a();
   endtask

   task automatic run_c(input iq_t e, input int kk, input int exp);
      arr_c   = pack_c(e);
      k_c     = (WC + 2)'(kk);
      start_c = 1'b1;
      exp_c_q.push_back(exp);
      @(negedge clk);
      start_c = 1'b0;
      wait_c();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      iq_t e, half;
      int kk;
      rst_n = 1'b0; start_a = 1'b0; clear_a = 1'b0; start_c = 1'b0; clear_c = 1'b0;
      arr_a = '0; k_a = '0; arr_c = '0; k_c = '0;
      half = fill(NA, 0);
      for (int i = 0; i < 4; i++) half[i] = 1;

      repeat (3) @(negedge clk);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_count_a", count_a, 0);
      chk("rst_count_c", count_c, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_busy_a", busy_a, 0);
      chk("idle_done_c", done_c, 0);

      // Fixed patterns with known answers.
      run_a(fill(NA, 0), 0, 70);
      repeat (5) @(negedge clk);
      chk("done_held_a", done_a, 1);
      chk("count_held_a", count_a, 70);
      // Back-to-back start from DONE: done drops on the next edge and count restarts.
      arr_a = pack_a(half); k_a = 4'd4; start_a = 1'b1; exp_a_q.push_back(1);
      @(negedge clk);
      start_a = 1'b0;
      chk("b2b_done_drop", done_a, 0);
      chk("b2b_busy", busy_a, 1);
      chk("b2b_count_zero", count_a, 0);
      wait_a();
      run_a(fill(NA, 3), 12, 70);
      run_a(fill(NA, 3), 11, 0);
      run_a(fill(NA, 3), 15, 0);
      run_a(half, 2, 36);
      run_a(half, 5, 0);

      // Random arrays against the model.
      for (int r = 0; r < 6; r++) begin
         e  = rand_q(NA, 3);
         kk = int'($urandom_range(2, 10));
         run_a(e, kk, quad_ref(e, kk));
      end

      // start and input changes mid-RUN must not disturb the captured run.
      e  = rand_q(NA, 3);
      kk = int'($urandom_range(3, 9));
      arr_a = pack_a(e); k_a = (WA + 2)'(kk); start_a = 1'b1;
      exp_a_q.push_back(quad_ref(e, kk));
      @(negedge clk);
      start_a = 1'b0;
      repeat (19) @(negedge clk);
      arr_a = ~arr_a; k_a = k_a + 4'd1; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      arr_a = 16'($urandom);
      wait_a();

      // Synchronous clear at cycle 30 of RUN.
      arr_a = '0; k_a = '0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (29) @(negedge clk);
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      chk("clr_busy_a", busy_a, 0);
      chk("clr_done_a", done_a, 0);
      chk("clr_count_a", count_a, 0);
      chk("clr_count_b", count_b, 0);
`ifdef QUAD_CNT_SAT_EN
      chk("clr_ovf_b", ovf_b, 0);
`endif
      repeat (3) @(negedge clk);
      chk("clr_stays_idle", busy_a, 0);

      // Clear from DONE.
      run_a(half, 2, 36);
      clear_a = 1'b1;
      @(negedge clk);
      clear_a = 1'b0;
      chk("clr_done_state", done_a, 0);
      chk("clr_done_count", count_a, 0);

      // Asynchronous reset at cycle 30 of RUN takes effect before the next edge.
      arr_a = '0; k_a = '0; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      repeat (29) @(negedge clk);
      chk("pre_rst_busy", busy_a, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_busy_a", busy_a, 0);
      chk("arst_done_a", done_a, 0);
      chk("arst_count_a", count_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst_idle_a", busy_a, 0);

      // Wider instance: W=3, N=12.
      run_c(fill(NC, 7), 28, 495);
      run_c(fill(NC, 7), 27, 0);
      for (int r = 0; r < 3; r++) begin
         e  = rand_q(NC, 7);
         kk = int'($urandom_range(10, 18));
         run_c(e, kk, quad_ref(e, kk));
      end

      repeat (3) @(negedge clk);
      chk("sb_a_leftover", exp_a_q.size(), 0);
      chk("sb_c_leftover", exp_c_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
